// File: rtl/shifter_pkg.sv
// shifter_pkg
// Shared types and constants for the shifter family.
//   state_t     : FSM state encoding for sequential shifters (IDLE, SHIFT)
//   OP_LOGICAL  : operation select, zero-fill shift
//   OP_ROTATE   : operation select, rotate
// The operation encoding is common with the combinational left barrel shifter.
package shifter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic OP_LOGICAL = 1'b0;
  localparam logic OP_ROTATE  = 1'b1;

endpackage

// File: rtl/shr1_step.sv
// shr1_step
// Combinational one-position right shift.
//   WIDTH     : data width (>= 2)
//   din       : input word
//   operation : OP_ROTATE moves bit 0 into the MSB, OP_LOGICAL fills the MSB with 0
//   dout      : shifted word
module shr1_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic             operation,
  output logic [WIDTH-1:0] dout
);

  logic fill;

  assign fill = (operation == OP_ROTATE) ? din[0] : 1'b0;
  assign dout = {fill, din[WIDTH-1:1]};

endmodule

// File: rtl/right_shifter_seq.sv
// right_shifter_seq
// Sequential right shifter / rotator, one bit position per clock.
//   WIDTH     : data width, power of two, >= 2
//   SHW       : shift-amount width, derived from WIDTH (do not override)
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request, sampled only while idle
//   datos     : operand, sampled with start
//   shift     : shift amount 0..WIDTH-1, sampled with start
//   operation : 1 = rotate right, 0 = logical shift right
//   busy      : high while a shift is in progress
//   done      : one-cycle pulse, salida valid from this cycle
//   salida    : result, held until the next result is written
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; salida holds the last result
// SHIFT | shifting work one position per edge until cnt reaches zero,
//       | then publishing the result and pulsing done
module right_shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] datos,
  input  logic [SHW-1:0]   shift,
  input  logic             operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] salida
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [SHW-1:0]   cnt;
  logic             op_q;

  shr1_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .din      (work),
    .operation(op_q),
    .dout     (work_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      op_q   <= OP_LOGICAL;
      salida <= '0;
      done   <= 1'b0;
    end else begin
      // done is a pulse: cleared unless the SHIFT branch sets it below
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= datos;
            cnt   <= shift;
            op_q  <= operation;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= work_next;
            cnt  <= cnt - SHW'(1);
          end else begin
            salida <= work;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_right_shifter_seq.sv
module tb_right_shifter_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] datos;
  logic [1:0]   shift;
  logic         operation;
  logic         busy;
  logic         done;
  logic [W-1:0] salida;

  int n_pass;
  int n_total;

  right_shifter_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .datos    (datos),
    .shift    (shift),
    .operation(operation),
    .busy     (busy),
    .done     (done),
    .salida   (salida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [1:0] s;
    logic       op;
    logic [3:0] exp;
  } vec_t;

  // Reference: rotate/shift expressed as plain arithmetic on the whole word
  function automatic logic [3:0] model(input logic [3:0] d, input int s, input logic op);
    int v;
    v = int'(d);
    if (op) return 4'(((v >> s) | (v << (W - s))) & 15);
    else    return 4'(v >> s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Steps from the current negedge until done is seen (bounded); lat counts edges
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [3:0] d, input logic [1:0] s, input logic op,
                        input logic [3:0] exp, input string tag);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; datos = d; shift = s; operation = op;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    datos = 4'($urandom); shift = 2'($urandom); operation = 1'($urandom);
    wait_done(lat, bcnt);
    chk({tag, " latency"}, lat, int'(s) + 1);
    chk({tag, " salida"}, int'(salida), int'(exp));
    chk({tag, " busy at done"}, int'(busy), 0);
    chk({tag, " busy cycles"}, bcnt, int'(s) + 1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done single"}, int'(done), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int lat, bcnt, dcnt;
    logic [3:0] rd;
    logic [1:0] rs;
    logic       rop;

    vecs[0] = '{4'b1011, 2'd1, 1'b1, 4'b1101};
    vecs[1] = '{4'b1011, 2'd3, 1'b1, 4'b0111};
    vecs[2] = '{4'b1011, 2'd2, 1'b0, 4'b0010};
    vecs[3] = '{4'b1011, 2'd3, 1'b0, 4'b0001};
    vecs[4] = '{4'b1001, 2'd0, 1'b0, 4'b1001};
    vecs[5] = '{4'b1001, 2'd0, 1'b1, 4'b1001};

    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; datos = '0; shift = '0; operation = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset salida", int'(salida), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("idle no done", dcnt, 0);

    // Directed table
    foreach (vecs[i]) run_op(vecs[i].d, vecs[i].s, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));

    // Busy protection: second start while busy must be ignored
    @(negedge clk);
    start = 1'b1; datos = 4'b1011; shift = 2'd3; operation = 1'b1;
    @(posedge clk);
    @(negedge clk);
    datos = 4'b1111; shift = 2'd1; operation = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("busyprot latency", lat + 1, 4);
    chk("busyprot salida", int'(salida), int'(4'b0111));

    // Back-to-back: start held through the done cycle
    start = 1'b1; datos = 4'b1000; shift = 2'd2; operation = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b no double done", int'(done), 0);
    chk("b2b busy", int'(busy), 1);
    wait_done(lat, bcnt);
    chk("b2b latency", lat, 3);
    chk("b2b salida", int'(salida), int'(4'b0010));

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; datos = 4'b0110; shift = 2'd3; operation = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst salida", int'(salida), 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst no done", dcnt, 0);
    run_op(4'b0110, 2'd1, 1'b1, 4'b0011, "after rst");

    // Random against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rd  = 4'($urandom_range(0, 15));
      rs  = 2'($urandom_range(0, 3));
      rop = 1'($urandom_range(0, 1));
      run_op(rd, rs, rop, model(rd, int'(rs), rop), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/right_shifter_seq.md
# right_shifter_seq

Sequential right shifter, the right-direction counterpart to the team's combinational 4-bit left barrel shifter. Accepts a word, a shift amount and an operation select on a start pulse. Shifts one bit position per clock and returns the result with a one-cycle `done` pulse. Used where a multi-cycle, area-cheap right shift/rotate is acceptable and the caller handshakes with `start`/`busy`/`done`.

## Interface
- `WIDTH`, default 4: data width. Must be a power of two and ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: width of the shift-amount port. Derived; do not override.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request. Sampled only when idle.
- `datos` in `WIDTH`: operand. Sampled with `start`.
- `shift` in `SHW`: shift amount, 0..`WIDTH`-1. Sampled with `start`.
- `operation` in 1: 1 = rotate right; 0 = logical shift right (zero fill from MSB). Sampled with `start`.
- `busy` out 1: high while a shift is in progress.
- `done` out 1: one-cycle pulse; `salida` is valid from this cycle.
- `salida` out `WIDTH`: result. Held until the next result is written.

## Operation
- States: `IDLE`, `SHIFT`.
- `IDLE`, `start`=1 at edge k:
  - Load working register ← `datos`.
  - Load count ← `shift`.
  - Latch `operation`.
  - Go to `SHIFT`.
- `SHIFT` at each edge:
  - If count ≠ 0:
    - Working register shifts right by 1. Rotate: bit 0 → MSB. Logical: MSB ← 0.
    - count ← count−1.
  - If count = 0:
    - `salida` ← working register.
    - `done` ← 1.
    - Go to `IDLE`.
- `busy` = (state == `SHIFT`). Combinational decode of the registered state.
- `done` is registered. It is cleared on every edge where it is not set.
- `start` while `busy`: ignored. No queuing, and latched inputs are unaffected.
- Input changes after edge k: no effect on the operation in flight.
- `shift`=0: passes `datos` unchanged for both operations.
- Rotate by n equals rotate left by `WIDTH`−n. A logical shift can never exceed `WIDTH`−1 positions.
- Reset values: state `IDLE`, `busy`=0, `done`=0, `salida`=0, working register 0, count 0.
- Reset asserted mid-operation: the operation is aborted immediately. No `done` is produced and `salida` returns to 0.

## Timing
- Latency: `start` sampled at edge k → `done`=1 and `salida` valid in the cycle after edge k+n+1, where n = `shift`.
- Examples: `shift`=0 gives 1 cycle; `shift`=`WIDTH`−1 gives `WIDTH` cycles.
- `busy`=1 in the cycles after edges k … k+n. It falls at the same edge that raises `done`.
- Back-to-back operation: `start` held high during the `done` cycle is sampled at the next edge.
  - This gives a throughput of one result per n+2 cycles.
- `done` is never high for two consecutive cycles from a single request.
- All outputs are glitch-free registered values, except `busy`, which is a decode of a registered state.

## Structure
- Shared package `shifter_pkg`:
  - State enum (`IDLE`, `SHIFT`).
  - Operation constants `OP_LOGICAL`=0 and `OP_ROTATE`=1. These are shared with the left barrel shifter's `operation` encoding.
- Sub-module `shr1_step`:
  - Combinational one-position right shift.
  - Inputs: `WIDTH`-bit word and `operation`. Output: `WIDTH`-bit result.
  - Instantiated once in the datapath.
- Top: FSM, counter, working register and output registers. No other hierarchy.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release → `salida`=0000, `busy`=0, `done`=0. No `done` pulse for 10 idle cycles.
- Rotate: `datos`=1011, `shift`=1, `operation`=1 → `salida`=1101 with `done` 2 cycles after the start edge. With `shift`=3 → `salida`=0111 after 4 cycles.
- Logical: `datos`=1011, `shift`=2, `operation`=0 → `salida`=0010 after 3 cycles. With `shift`=3 → 0001.
- Zero shift: `datos`=1001, `shift`=0, either operation → `salida`=1001 with `done` 1 cycle after start and `busy` high for exactly 1 cycle.
- Busy protection / back-to-back:
  - Start (1011, 3, rotate), then pulse `start` with (1111, 1, logical) while `busy` → single `done`, `salida`=0111.
  - Then `start` held through the `done` cycle with (1000, 2, logical) → next `done` with `salida`=0010.
- Reset mid-operation: start (0110, 3, rotate), assert `rst` asynchronously 2 cycles later between edges → `busy`, `done`, `salida` go to 0 immediately. No `done` after release. A new start (0110, 1, rotate) yields 0011.
